// File: rtl/bcd_7seg_scan_if.sv
// bcd_7seg_scan_if: display bus; master drives bcd/load/blank_lz, slave returns seg/an/err/frame_done
interface bcd_7seg_scan_if;
    logic [15:0] bcd;
    logic        load;
    logic        blank_lz;
    logic [6:0]  seg;
    logic [3:0]  an;
    logic        err;
    logic        frame_done;
    modport master (output bcd, load, blank_lz, input seg, an, err, frame_done);
    modport slave  (input bcd, load, blank_lz, output seg, an, err, frame_done);
endinterface

// File: rtl/bcd_7seg_scan.sv
// bcd_7seg_scan: 4-digit BCD to multiplexed 7-segment driver (clock, async a_rst_n, bus: bcd/load/blank_lz in, seg/an/err/frame_done out)
module bcd_7seg_scan #(
    parameter int unsigned REFRESH_DIV = 50000
) (
    input logic             clock,
    input logic             a_rst_n,
    bcd_7seg_scan_if.slave  bus
);
    typedef enum logic {IDLE, SCAN} state_t;
    localparam logic [15:0] LAST = 16'(REFRESH_DIV - 1);
    state_t      state_q, state_d;
    logic [15:0] active_q, active_d, pending_q, pending_d, div_cnt_q, div_cnt_d;
    logic        pend_q, pend_d, armed_q, err_q, err_d, frame_done_q, frame_done_d;
    logic [1:0]  idx_q, idx_d;
    logic [6:0]  seg_q, seg_d;
    logic [3:0]  an_q, an_d, digit;
    logic        load_ok, wrap, boundary, z3, z2, z1, blank;
    function automatic logic [6:0] enc(input logic [3:0] d);
        case (d)
            4'd0: enc = 7'h3F;
            4'd1: enc = 7'h06;
            4'd2: enc = 7'h5B;
            4'd3: enc = 7'h4F;
            4'd4: enc = 7'h66;
            4'd5: enc = 7'h6D;
            4'd6: enc = 7'h7D;
            4'd7: enc = 7'h07;
            4'd8: enc = 7'h7F;
            4'd9: enc = 7'h6F;
            default: enc = 7'h40;
        endcase
    endfunction
    always_comb begin
        load_ok      = bus.load && armed_q;
        wrap         = div_cnt_q == LAST;
        boundary     = state_q == SCAN && wrap && idx_q == 2'd3;
        state_d      = state_q;
        active_d     = active_q;
        pending_d    = pending_q;
        pend_d       = pend_q;
        div_cnt_d    = div_cnt_q;
        idx_d        = idx_q;
        if (state_q == IDLE) begin
            if (load_ok) begin
                active_d  = bus.bcd;
                state_d   = SCAN;
                div_cnt_d = '0;
                idx_d     = '0;
            end
        end else begin
            div_cnt_d = wrap ? '0 : div_cnt_q + 16'd1;
            idx_d     = wrap ? idx_q + 2'd1 : idx_q;
            if (boundary && load_ok) begin
                active_d  = bus.bcd;
                pending_d = '0;
                pend_d    = 1'b0;
            end else if (boundary && pend_q) begin
                active_d = pending_q;
                pend_d   = 1'b0;
            end else if (load_ok) begin
                pending_d = bus.bcd;
                pend_d    = 1'b1;
            end
        end
        frame_done_d = boundary;
        digit        = 4'(active_q >> {idx_q, 2'b00});
        z3           = active_q[15:12] == 4'd0;
        z2           = z3 && active_q[11:8] == 4'd0;
        z1           = z2 && active_q[7:4] == 4'd0;
        blank        = bus.blank_lz && (idx_q == 2'd3 ? z3 : idx_q == 2'd2 ? z2 : idx_q == 2'd1 ? z1 : 1'b0);
        seg_d        = state_q == SCAN && !blank ? enc(digit) : 7'h00;
        an_d         = state_q == SCAN ? ~(4'b0001 << idx_q) : 4'hF;
        err_d        = active_q[15:12] > 4'd9 || active_q[11:8] > 4'd9 || active_q[7:4] > 4'd9 || active_q[3:0] > 4'd9;
    end
    // armed_q masks a load that arrives in the first cycle after reset release
    always_ff @(posedge clock or negedge a_rst_n) begin
        if (!a_rst_n) begin
            state_q      <= IDLE;
            active_q     <= '0;
            pending_q    <= '0;
            pend_q       <= 1'b0;
            div_cnt_q    <= '0;
            idx_q        <= '0;
            armed_q      <= 1'b0;
            seg_q        <= '0;
            an_q         <= 4'hF;
            err_q        <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            active_q     <= active_d;
            pending_q    <= pending_d;
            pend_q       <= pend_d;
            div_cnt_q    <= div_cnt_d;
            idx_q        <= idx_d;
            armed_q      <= 1'b1;
            seg_q        <= seg_d;
            an_q         <= an_d;
            err_q        <= err_d;
            frame_done_q <= frame_done_d;
        end
    end
    assign bus.seg        = seg_q;
    assign bus.an         = an_q;
    assign bus.err        = err_q;
    assign bus.frame_done = frame_done_q;
endmodule

// File: doc/bcd_7seg_scan.md
BCD_7SEG_SCAN -- requirements
Module: bcd_7seg_scan

Interface
REQ-001 SHALL have parameter REFRESH_DIV, default 50000, clock cycles per digit slot (legal range 2..65535).
REQ-002 SHALL have port clock, input, 1, the single clock; all flops are rising-edge.
REQ-003 SHALL have port a_rst_n, input, 1; one clock; reset is asynchronous and active-low.
REQ-004 SHALL have port bcd, input, 16, four packed BCD digits, digit3 = [15:12], digit0 = [3:0].
REQ-005 SHALL have port load, input, 1, single-cycle capture strobe for bcd.
REQ-006 SHALL have port blank_lz, input, 1, leading-zero blanking enable, sampled every cycle.
REQ-007 SHALL have port seg, output, 7, {g,f,e,d,c,b,a}, active-high, registered.
REQ-008 SHALL have port an, output, 4, digit enables, one-hot active-low, registered.
REQ-009 SHALL have port err, output, 1, high while the active value holds any nibble > 9.
REQ-010 SHALL have port frame_done, output, 1, one-cycle pulse at the end of each digit3 slot.

Function
REQ-011 SHALL use a two-state FSM.
- IDLE: an = 4'hF, seg = 0.
- SCAN: digits multiplexed.
REQ-012 SHALL hold two 16-bit registers.
- active: the value displayed.
- pending: the value captured by load, with a pend flag.
REQ-013 In IDLE, load SHALL write bcd to active and move to SCAN on the next edge, with digit index = 0 and div_cnt = 0.
REQ-014 In SCAN, load SHALL write bcd to pending and set pend; a later load before the frame boundary SHALL overwrite pending (last wins).
REQ-015 div_cnt SHALL count 0..REFRESH_DIV-1.
- At REFRESH_DIV-1 it SHALL wrap to 0 and the digit index SHALL advance 0->1->2->3->0.
REQ-016 The frame boundary is the cycle with div_cnt = REFRESH_DIV-1 and digit index = 3.
- frame_done SHALL be registered high in the following cycle.
- If pend = 1, pending SHALL be copied to active and pend cleared.
REQ-017 If load coincides with the frame boundary, bcd SHALL go directly to active, pending SHALL be discarded, and pend cleared.
REQ-018 Active SHALL never change mid-frame while in SCAN (no digit tearing).
REQ-019 seg and an SHALL reflect the digit index and active value with exactly one cycle of latency.
- Digit index i drives an[i] = 0 and all other an bits = 1.
REQ-020 Segment encoding SHALL be: 0=0x3F, 1=0x06, 2=0x5B, 3=0x4F, 4=0x66, 5=0x6D, 6=0x7D, 7=0x07, 8=0x7F, 9=0x6F, 10..15=0x40 (dash).
REQ-021 With blank_lz = 1, digit k (k = 3, 2, 1) SHALL output seg = 0x00 when digit k and all higher digits are 0.
- Its an bit SHALL still be driven low.
- Digit0 SHALL never be blanked.
REQ-022 err SHALL be registered, computed combinationally from active, and updated the cycle after active changes.
REQ-023 Once in SCAN, the block SHALL stay in SCAN until reset; there is no return to IDLE via load.

Reset
REQ-024 On a_rst_n low, asynchronously:
- seg = 0, an = 4'hF, err = 0, frame_done = 0
- active = 0, pending = 0, pend = 0
- div_cnt = 0, digit index = 0, state = IDLE
REQ-025 Reset asserted mid-scan SHALL blank the display immediately and discard pending.
- After release, the block SHALL remain in IDLE until the next load.
REQ-026 load asserted in the same cycle as reset release SHALL be ignored.

Verification (REFRESH_DIV = 4)
REQ-027 Hold a_rst_n = 0 with load and bcd toggling -> seg = 0x00, an = 4'hF, err = 0 throughout; after release with no load, outputs stay unchanged.
REQ-028 Apply load with bcd = 16'h9801, blank_lz = 0.
- an sequence: 1110, 1101, 1011, 0111, each for 4 cycles.
- seg per slot: 0x06, 0x3F, 0x7F, 0x6F.
- frame_done pulses every 16 cycles; err = 0.
REQ-029 Apply bcd = 16'h0042 with blank_lz = 1 -> seg per slot 0x5B, 0x66, 0x00, 0x00; bcd = 16'h0000 -> seg 0x3F, 0x00, 0x00, 0x00.
REQ-030 Apply bcd = 16'h12A4 -> err = 1; seg per slot 0x66, 0x40, 0x5B, 0x06.
REQ-031 Load 16'h1111, then load 16'h2222 during the digit1 slot -> digits 2 and 3 of the current frame show 0x06; the next frame shows 0x5B in all slots. Load coinciding with the boundary cycle -> the new value shows in the next frame.
REQ-032 Assert a_rst_n during the digit2 slot with pend = 1 -> an = 4'hF on the same edge; after release, the display stays blank and the pending value never appears.
